// File: rtl/avr_wait_arb_pkg.sv
// Shared definitions for the AVR wait-state arbiter.
//   state_e   : arbiter FSM encoding
//   SRC_GLU / SRC_COM : source identifiers (grant register and avr_src value)
//   DATA_DFLT : idle/abort value for rdata and wait_write
package avr_wait_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWait,
    StAck,
    StRel
  } state_e;

  localparam logic       SRC_GLU   = 1'b0;
  localparam logic       SRC_COM   = 1'b1;
  localparam logic [7:0] DATA_DFLT = 8'hFF;

endpackage

// File: rtl/avr_wait_tmo.sv
// Timeout counter for a pending AVR transfer.
//   fclk, rst_n : clock and asynchronous active-low reset
//   clr         : restart the count from zero
//   run         : count one cycle of waiting
//   expire      : high in the waiting cycle whose increment reaches all-ones
module avr_wait_tmo #(
  parameter int unsigned TMO_W = 16
) (
  input  logic fclk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic expire
);

  localparam logic [TMO_W-1:0] CntLast = {{(TMO_W-1){1'b1}}, 1'b0};

  logic [TMO_W-1:0] cnt_q;

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Fires as the count steps onto all-ones, so the wait ends after 2^TMO_W - 1 cycles.
  assign expire = run && (cnt_q == CntLast);

endmodule

// File: rtl/avr_wait_arb.sv
// Arbiter between the gluclock and comport requesters for AVR accesses via the SPI slave.
//   fclk, rst_n                    : clock, asynchronous active-low reset
//   glu_req/rnw/addr/wdata, glu_ack: gluclock requester handshake
//   com_req/rnw/addr/wdata, com_ack: comport requester handshake
//   rdata                          : read result, valid in the ack cycle
//   wait_rnw, wait_write           : latched direction/write data for the AVR
//   wait_read, wait_end            : AVR read data and completion pulse
//   gluclock_addr, comport_addr    : latched per-source addresses
//   avr_req, avr_src, busy, tmo    : status outputs
// Optional timeout: define AVR_WAIT_TMO_EN to abort a WAIT after 2^TMO_W - 1 cycles.
module avr_wait_arb
  import avr_wait_arb_pkg::*;
#(
  parameter int unsigned TMO_W = 16
) (
  input  logic       fclk,
  input  logic       rst_n,
  input  logic       glu_req,
  input  logic       glu_rnw,
  input  logic [7:0] glu_addr,
  input  logic [7:0] glu_wdata,
  output logic       glu_ack,
  input  logic       com_req,
  input  logic       com_rnw,
  input  logic [2:0] com_addr,
  input  logic [7:0] com_wdata,
  output logic       com_ack,
  output logic [7:0] rdata,
  output logic       wait_rnw,
  output logic [7:0] wait_write,
  input  logic [7:0] wait_read,
  input  logic       wait_end,
  output logic [7:0] gluclock_addr,
  output logic [2:0] comport_addr,
  output logic       avr_req,
  output logic       avr_src,
  output logic       busy,
  output logic       tmo
);

  state_e state_q, state_d;
  logic   grant_q, grant_d;  // current grant; doubles as last-grant memory
  logic   tmo_hit;           // terminal count with no wait_end this cycle
  logic   tmo_q;

`ifdef AVR_WAIT_TMO_EN
  logic tmo_exp;

  avr_wait_tmo #(
    .TMO_W (TMO_W)
  ) u_tmo (
    .fclk   (fclk),
    .rst_n  (rst_n),
    .clr    (state_q == StLoad),
    .run    (state_q == StWait),
    .expire (tmo_exp)
  );

  assign tmo_hit = tmo_exp & ~wait_end;
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    unique case (state_q)
      StIdle: begin
        if (glu_req || com_req) begin
          state_d = StLoad;
          if (glu_req && com_req) begin
            grant_d = ~grant_q;
          end else begin
            grant_d = glu_req ? SRC_GLU : SRC_COM;
          end
        end
      end
      StLoad: state_d = StWait;
      StWait: begin
        if (wait_end || tmo_hit) begin
          state_d = StAck;
        end
      end
      StAck:  state_d = StRel;
      StRel:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= SRC_COM;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      wait_rnw      <= 1'b0;
      wait_write    <= DATA_DFLT;
      gluclock_addr <= '0;
      comport_addr  <= '0;
      rdata         <= DATA_DFLT;
      tmo_q         <= 1'b0;
    end else begin
      tmo_q <= (state_q == StWait) && tmo_hit;
      if (state_q == StLoad) begin
        if (grant_q == SRC_GLU) begin
          wait_rnw      <= glu_rnw;
          wait_write    <= glu_wdata;
          gluclock_addr <= glu_addr;
        end else begin
          wait_rnw     <= com_rnw;
          wait_write   <= com_wdata;
          comport_addr <= com_addr;
        end
      end
      if (state_q == StWait) begin
        if (wait_end) begin
          if (wait_rnw) begin
            rdata <= wait_read;
          end
        end else if (tmo_hit) begin
          rdata <= DATA_DFLT;
        end
      end
    end
  end

  assign busy    = (state_q != StIdle);
  assign avr_req = (state_q == StWait);
  assign avr_src = busy & grant_q;
  assign glu_ack = (state_q == StAck) && (grant_q == SRC_GLU);
  assign com_ack = (state_q == StAck) && (grant_q == SRC_COM);
  assign tmo     = tmo_q;

endmodule

// File: tb/tb_avr_wait_arb.sv
module tb_avr_wait_arb;

  logic       fclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       glu_req = 1'b0, glu_rnw = 1'b0;
  logic [7:0] glu_addr = '0, glu_wdata = '0;
  logic       glu_ack;
  logic       com_req = 1'b0, com_rnw = 1'b0;
  logic [2:0] com_addr = '0;
  logic [7:0] com_wdata = '0;
  logic       com_ack;
  logic [7:0] rdata;
  logic       wait_rnw;
  logic [7:0] wait_write;
  logic [7:0] wait_read = '0;
  logic       wait_end = 1'b0;
  logic [7:0] gluclock_addr;
  logic [2:0] comport_addr;
  logic       avr_req, avr_src, busy, tmo;

  int checks = 0;
  int failures = 0;

  avr_wait_arb #(
    .TMO_W (4)
  ) dut (
    .fclk          (fclk),
    .rst_n         (rst_n),
    .glu_req       (glu_req),
    .glu_rnw       (glu_rnw),
    .glu_addr      (glu_addr),
    .glu_wdata     (glu_wdata),
    .glu_ack       (glu_ack),
    .com_req       (com_req),
    .com_rnw       (com_rnw),
    .com_addr      (com_addr),
    .com_wdata     (com_wdata),
    .com_ack       (com_ack),
    .rdata         (rdata),
    .wait_rnw      (wait_rnw),
    .wait_write    (wait_write),
    .wait_read     (wait_read),
    .wait_end      (wait_end),
    .gluclock_addr (gluclock_addr),
    .comport_addr  (comport_addr),
    .avr_req       (avr_req),
    .avr_src       (avr_src),
    .busy          (busy),
    .tmo           (tmo)
  );

  always #5 fclk = ~fclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  // One transfer: drive reqs, expect source exp_src, end WAIT on cycle n with read data rd.
  task automatic xfer(input logic g, input logic c, input logic exp_src, input int n,
                      input logic [7:0] rd, input logic [7:0] exp_rdata);
    glu_req = g;
    com_req = c;
    tick();  // LOAD
    check_eq("load_busy", busy, 1);
    check_eq("load_src", avr_src, exp_src);
    check_eq("load_avr_req", avr_req, 0);
    tick();  // WAIT 1
    for (int i = 1; i <= n; i++) begin
      check_eq("wait_avr_req", avr_req, 1);
      check_eq("wait_no_ack", glu_ack | com_ack, 0);
      if (i == n) begin
        wait_end  = 1'b1;
        wait_read = rd;
      end
      tick();
      wait_end = 1'b0;
    end
    check_eq("ack_glu", glu_ack, exp_src == 1'b0);
    check_eq("ack_com", com_ack, exp_src == 1'b1);
    check_eq("ack_rdata", rdata, exp_rdata);
    check_eq("ack_src", avr_src, exp_src);
    check_eq("ack_tmo", tmo, 0);
    check_eq("ack_avr_req", avr_req, 0);
    if (exp_src == 1'b0) glu_req = 1'b0;
    else com_req = 1'b0;
    tick();  // REL
    check_eq("rel_ack", glu_ack | com_ack, 0);
    check_eq("rel_busy", busy, 1);
    tick();  // IDLE
    check_eq("idle_busy", busy, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    // Reset values.
    tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rdata", rdata, 8'hFF);
    check_eq("rst_wait_write", wait_write, 8'hFF);
    check_eq("rst_wait_rnw", wait_rnw, 0);
    check_eq("rst_glu_addr", gluclock_addr, 0);
    check_eq("rst_com_addr", comport_addr, 0);
    check_eq("rst_acks", {glu_ack, com_ack, avr_req, avr_src, tmo}, 0);
    #2 rst_n = 1'b1;

    // glu read of 0x0C, wait_end 5 cycles into WAIT.
    glu_rnw = 1'b1; glu_addr = 8'h0C; glu_wdata = 8'h00;
    xfer(1'b1, 1'b0, 1'b0, 5, 8'h5A, 8'h5A);
    check_eq("r1_glu_addr", gluclock_addr, 8'h0C);
    check_eq("r1_rnw", wait_rnw, 1);
    check_eq("r1_wait_write", wait_write, 8'h00);

    // com write of addr 5, data 0xA3; rdata must stay 0x5A.
    com_rnw = 1'b0; com_addr = 3'd5; com_wdata = 8'hA3;
    xfer(1'b0, 1'b1, 1'b1, 2, 8'h77, 8'h5A);
    check_eq("w_com_addr", comport_addr, 5);
    check_eq("w_wait_write", wait_write, 8'hA3);
    check_eq("w_rnw", wait_rnw, 0);
    check_eq("w_glu_addr_held", gluclock_addr, 8'h0C);

    // Stray wait_end in IDLE is ignored.
    wait_end = 1'b1; wait_read = 8'h33;
    tick();
    wait_end = 1'b0;
    check_eq("stray_busy", busy, 0);
    check_eq("stray_rdata", rdata, 8'h5A);
    glu_addr = 8'h42;
    xfer(1'b1, 1'b0, 1'b0, 3, 8'hC3, 8'hC3);
    check_eq("stray_glu_addr", gluclock_addr, 8'h42);

    // Round robin from reset: glu first, then com, then glu again.
    do_reset();
    glu_rnw = 1'b1; glu_addr = 8'h11;
    com_rnw = 1'b1; com_addr = 3'd2;
    xfer(1'b1, 1'b1, 1'b0, 1, 8'hA1, 8'hA1);
    xfer(1'b1, 1'b1, 1'b1, 2, 8'hB2, 8'hB2);
    check_eq("rr_com_addr", comport_addr, 2);
    xfer(1'b1, 1'b0, 1'b0, 1, 8'hC4, 8'hC4);

    // Reset during WAIT aborts with no ack; held req is re-granted.
    glu_rnw = 1'b1; glu_addr = 8'h55; glu_req = 1'b1;
    tick();
    tick();
    tick();
    check_eq("mid_avr_req", avr_req, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_busy", busy, 0);
    check_eq("mid_ack", glu_ack | com_ack, 0);
    check_eq("mid_rdata", rdata, 8'hFF);
    tick();
    check_eq("mid_ack2", glu_ack | com_ack | busy, 0);
    #2 rst_n = 1'b1;
    xfer(1'b1, 1'b0, 1'b0, 2, 8'h99, 8'h99);
    check_eq("mid_glu_addr", gluclock_addr, 8'h55);

`ifdef AVR_WAIT_TMO_EN
    begin
      int cnt = 0;
      logic early = 1'b0;
      glu_rnw = 1'b1; glu_addr = 8'h20; glu_req = 1'b1;
      tick();  // LOAD
      tick();  // WAIT 1
      while (!glu_ack && cnt < 40) begin
        if (avr_req) cnt++;
        if (tmo) early = 1'b1;
        tick();
      end
      check_eq("tmo_ack", glu_ack, 1);
      check_eq("tmo_wait_cycles", cnt, 15);
      check_eq("tmo_early", early, 0);
      check_eq("tmo_pulse", tmo, 1);
      check_eq("tmo_rdata", rdata, 8'hFF);
      glu_req = 1'b0;
      tick();
      check_eq("tmo_one_cycle", tmo, 0);
      tick();
      // wait_end on the terminal cycle wins over the timeout.
      xfer(1'b1, 1'b0, 1'b0, 15, 8'h6D, 8'h6D);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/avr_wait_arb.md
AVR_WAIT_ARB -- requirements
Module: avr_wait_arb

Interface
REQ-001 Parameter TMO_W, default 16, sets the timeout counter width in bits.
REQ-002 fclk  in  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 glu_req  in  1  gluclock requester; held high until glu_ack.
REQ-005 glu_rnw  in  1  gluclock access: 1 = read, 0 = write.
REQ-006 glu_addr  in  8  gluclock register address.
REQ-007 glu_wdata  in  8  gluclock write data.
REQ-008 glu_ack  out  1  one-cycle completion pulse to the gluclock requester.
REQ-009 com_req / com_rnw / com_addr[2:0] / com_wdata[7:0]  in  comport requester, same rules as the glu_* inputs.
REQ-010 com_ack  out  1  one-cycle completion pulse to the comport requester.
REQ-011 rdata  out  8  read result; valid during the ack cycle.
REQ-012 wait_rnw  out  1  direction of the current transfer, sent to the SPI slave.
REQ-013 wait_write  out  8  write data for the AVR.
REQ-014 wait_read  in  8  data returned by the AVR.
REQ-015 wait_end  in  1  one-cycle pulse from the SPI slave when the AVR finishes.
REQ-016 gluclock_addr  out  8  latched gluclock address.
REQ-017 comport_addr  out  3  latched comport address.
REQ-018 avr_req  out  1  status bit: a transfer is pending for the AVR.
REQ-019 avr_src  out  1  status bit: current source, 0 = glu, 1 = com.
REQ-020 busy  out  1  high in every state except IDLE; drives the Z80 wait.
REQ-021 tmo  out  1  one-cycle pulse when a transfer is aborted by timeout.

Function
REQ-022 The FSM SHALL have states IDLE, LOAD, WAIT, ACK and REL.
REQ-023 IDLE SHALL go to LOAD when any req is high; with no req it stays in IDLE.
- The grant is latched on that edge.
- If both reqs are high, the source not granted last wins; after reset, glu wins.
REQ-024 LOAD SHALL latch the granted rnw, address and wdata into wait_rnw, the matching *_addr and wait_write, then go to WAIT.
- The other source's address output is unchanged.
REQ-025 avr_req SHALL be 1 in WAIT only; avr_src SHALL show the latched grant from LOAD through REL.
REQ-026 In WAIT, wait_end SHALL move the FSM to ACK.
- On that edge, rdata captures wait_read if rnw = 1; otherwise rdata is unchanged.
REQ-027 wait_end outside WAIT SHALL be ignored.
REQ-028 ACK SHALL pulse the granted *_ack for exactly one cycle, then go to REL.
REQ-029 REL SHALL last one cycle, ignore all reqs, then go to IDLE.
- Requesters drop req in the cycle after ack.
REQ-030 Latency from req sampled high to ack is 3 + N cycles, where N is the number of WAIT cycles (N >= 1).
REQ-031 The latched outputs wait_rnw, wait_write and *_addr SHALL hold their values after the transfer until the next LOAD.

Reset
REQ-032 While rst_n = 0, the block SHALL set:
- FSM to IDLE;
- all outputs to 0, except rdata = 8'hFF and wait_write = 8'hFF;
- the last-grant state to com, so glu wins first.
REQ-033 Reset asserted mid-transfer SHALL abort the transfer with no ack, and the aborted request SHALL be re-arbitrated after release.

Configuration
REQ-034 The feature macro is AVR_WAIT_TMO_EN.
- Defined: a TMO_W counter clears in LOAD and increments each WAIT cycle. When it reaches all-ones with no wait_end, the FSM goes to ACK with rdata = 8'hFF and tmo pulses for one cycle.
- wait_end and the terminal count in the same cycle: wait_end wins and tmo stays 0.
- Undefined: no counter; WAIT lasts indefinitely; tmo is tied to 0.

Structure
REQ-035 A shared package SHALL hold the state encoding, the SRC_GLU and SRC_COM constants, and the 8'hFF default data constant.
REQ-036 The timeout counter SHALL be a sub-module, avr_wait_tmo, instantiated only under AVR_WAIT_TMO_EN.

Verification
REQ-037 glu read of addr 8'h0C; wait_end 5 cycles into WAIT with wait_read = 8'h5A:
- gluclock_addr = 8'h0C;
- avr_req high for 5 cycles;
- glu_ack with rdata = 8'h5A.
REQ-038 Both reqs high in the same cycle, repeated twice: the first transfer serves glu (avr_src = 0), the second serves com (avr_src = 1).
REQ-039 com write of addr 3'd5, data 8'hA3: comport_addr = 5, wait_write = 8'hA3, wait_rnw = 0, com_ack pulses, and rdata is unchanged.
REQ-040 wait_end pulsed in IDLE, then a glu request: the stray pulse is ignored and the glu transfer still waits for its own wait_end.
REQ-041 With AVR_WAIT_TMO_EN and TMO_W = 4, no wait_end: tmo pulses after 15 WAIT cycles, and glu_ack arrives with rdata = 8'hFF.
REQ-042 rst_n pulsed low during WAIT: busy = 0 at once, no ack is issued, and the held req is re-granted after reset release.
